// File: rtl/crc_stream_appender.sv
// Streaming CRC generator: forwards a framed word stream unchanged and
// appends the final CRC as CRC_W/DATA_W trailing words.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last     input stream (valid/ready)
//   m_valid/m_ready/m_data/m_last     output stream, single register stage
//   crc_value/crc_done                final CRC of last frame + update strobe
module crc_stream_appender #(
    parameter int               CRC_W            = 16,
    parameter int               DATA_W           = 8,
    parameter logic [CRC_W-1:0] POLY             = 16'h8005,
    parameter logic [CRC_W-1:0] INIT             = '0,
    parameter bit               REFIN            = 1'b0,
    parameter bit               REFOUT           = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT           = '0,
    parameter bit               APPEND_LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CRC_W-1:0]  crc_value,
    output logic              crc_done
);

    localparam int NW = CRC_W / DATA_W;
    localparam int CW = (NW > 1) ? $clog2(NW + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_APPEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CRC_W-1:0]  r_crc;
    logic [CRC_W-1:0]  r_final;
    logic [CW-1:0]     r_cnt;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_last;
    logic [CRC_W-1:0]  r_crc_value;
    logic              r_crc_done;

    logic              w_out_free;
    logic              w_in_xfer;
    logic [DATA_W-1:0] w_din;
    logic [CRC_W-1:0]  w_crc_upd;
    logic [CRC_W-1:0]  w_final;
    logic              w_load_crc;
    logic              w_app_done;
    logic [CW-1:0]     w_idx;
    logic [DATA_W-1:0] w_crc_word;

    function automatic logic [DATA_W-1:0] rev_data(
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] rev_crc(
        input logic [CRC_W-1:0] d
    );
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_W; i++) r[i] = d[CRC_W-1-i];
        return r;
    endfunction

    // DATA_W serial LFSR steps, MSB of the word first, unrolled.
    function automatic logic [CRC_W-1:0] crc_update(
        input logic [CRC_W-1:0]  c_in,
        input logic [DATA_W-1:0] d
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    // The output register can take a new word when empty or draining now.
    assign w_out_free = !r_m_valid || m_ready;
    assign s_ready    = (r_state != S_APPEND) && w_out_free;
    assign w_in_xfer  = s_valid && s_ready;

    assign w_din     = REFIN ? rev_data(s_data) : s_data;
    assign w_crc_upd = crc_update(r_crc, w_din);
    assign w_final   = (REFOUT ? rev_crc(w_crc_upd) : w_crc_upd) ^ XOROUT;

    // r_cnt counts CRC words already loaded; NW means all are in flight.
    assign w_load_crc = (r_state == S_APPEND) && w_out_free
                        && (r_cnt != CW'(NW));
    assign w_app_done = (r_state == S_APPEND) && (r_cnt == CW'(NW))
                        && r_m_valid && m_ready;

    assign w_idx      = APPEND_LSB_FIRST ? r_cnt : (CW'(NW - 1) - r_cnt);
    assign w_crc_word = DATA_W'(r_final >> (w_idx * DATA_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_in_xfer) begin
                    w_state_nxt = s_last ? S_APPEND : S_DATA;
                end
            end
            S_DATA: begin
                if (w_in_xfer && s_last) begin
                    w_state_nxt = S_APPEND;
                end
            end
            S_APPEND: begin
                if (w_app_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc       <= INIT;
            r_final     <= '0;
            r_cnt       <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
            r_crc_value <= '0;
            r_crc_done  <= 1'b0;
        end else begin
            r_crc_done <= 1'b0;
            if (w_in_xfer) begin
                r_m_valid <= 1'b1;
                r_m_data  <= s_data;
                r_m_last  <= 1'b0;
                r_crc     <= w_crc_upd;
                if (s_last) begin
                    r_final     <= w_final;
                    r_crc_value <= w_final;
                    r_crc_done  <= 1'b1;
                    r_cnt       <= '0;
                end
            end else if (w_load_crc) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_crc_word;
                r_m_last  <= (r_cnt == CW'(NW - 1));
                r_cnt     <= r_cnt + 1'b1;
            end else if (w_out_free) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            if (w_app_done) begin
                r_crc <= INIT;
            end
        end
    end

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_last    = r_m_last;
    assign crc_value = r_crc_value;
    assign crc_done  = r_crc_done;

endmodule

// File: tb/tb_crc_stream_appender.sv
// Bench for crc_stream_appender: three configurations (BUYPASS, ARC,
// 32-bit-wide CRC-32) driven by directed frames, checked by a scoreboard.
module tb_crc_stream_appender;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sv [3];
    logic [31:0] sd [3];
    logic        sl [3];
    logic        mr [3];
    logic        sr [3];
    logic        mv [3];
    logic        ml [3];
    logic        cd [3];
    logic [31:0] md [3];
    logic [63:0] cv [3];

    wire        w_sr0, w_mv0, w_ml0, w_cd0;
    wire [7:0]  w_md0;
    wire [15:0] w_cv0;
    wire        w_sr1, w_mv1, w_ml1, w_cd1;
    wire [7:0]  w_md1;
    wire [15:0] w_cv1;
    wire        w_sr2, w_mv2, w_ml2, w_cd2;
    wire [31:0] w_md2;
    wire [31:0] w_cv2;

    crc_stream_appender u0 (
        .clk(clk), .rst(rst),
        .s_valid(sv[0]), .s_ready(w_sr0), .s_data(sd[0][7:0]),
        .s_last(sl[0]), .m_valid(w_mv0), .m_ready(mr[0]),
        .m_data(w_md0), .m_last(w_ml0),
        .crc_value(w_cv0), .crc_done(w_cd0)
    );

    crc_stream_appender #(
        .REFIN(1'b1), .REFOUT(1'b1), .APPEND_LSB_FIRST(1'b1)
    ) u1 (
        .clk(clk), .rst(rst),
        .s_valid(sv[1]), .s_ready(w_sr1), .s_data(sd[1][7:0]),
        .s_last(sl[1]), .m_valid(w_mv1), .m_ready(mr[1]),
        .m_data(w_md1), .m_last(w_ml1),
        .crc_value(w_cv1), .crc_done(w_cd1)
    );

    crc_stream_appender #(
        .CRC_W(32), .DATA_W(32), .POLY(32'h04C11DB7),
        .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
        .REFIN(1'b1), .REFOUT(1'b1), .APPEND_LSB_FIRST(1'b1)
    ) u2 (
        .clk(clk), .rst(rst),
        .s_valid(sv[2]), .s_ready(w_sr2), .s_data(sd[2]),
        .s_last(sl[2]), .m_valid(w_mv2), .m_ready(mr[2]),
        .m_data(w_md2), .m_last(w_ml2),
        .crc_value(w_cv2), .crc_done(w_cd2)
    );

    assign sr[0] = w_sr0;
    assign sr[1] = w_sr1;
    assign sr[2] = w_sr2;
    assign mv[0] = w_mv0;
    assign mv[1] = w_mv1;
    assign mv[2] = w_mv2;
    assign ml[0] = w_ml0;
    assign ml[1] = w_ml1;
    assign ml[2] = w_ml2;
    assign cd[0] = w_cd0;
    assign cd[1] = w_cd1;
    assign cd[2] = w_cd2;
    assign md[0] = {24'h0, w_md0};
    assign md[1] = {24'h0, w_md1};
    assign md[2] = w_md2;
    assign cv[0] = {48'h0, w_cv0};
    assign cv[1] = {48'h0, w_cv1};
    assign cv[2] = {32'h0, w_cv2};

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard: {m_last, m_data} per output word, and final CRCs.
    logic [32:0] exp_q [3][$];
    logic [63:0] crc_q [3][$];

    function automatic void push_crc(int k, logic [63:0] c);
        case (k)
            0: begin
                exp_q[0].push_back({1'b0, 24'h0, c[15:8]});
                exp_q[0].push_back({1'b1, 24'h0, c[7:0]});
            end
            1: begin
                exp_q[1].push_back({1'b0, 24'h0, c[7:0]});
                exp_q[1].push_back({1'b1, 24'h0, c[15:8]});
            end
            default: exp_q[2].push_back({1'b1, c[31:0]});
        endcase
        crc_q[k].push_back(c);
    endfunction

    // Reference models, byte-serial textbook forms.
    function automatic logic [15:0] m_buypass(logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'h0;
        foreach (b[i]) begin
            c = c ^ {b[i], 8'h00};
            for (int j = 0; j < 8; j++)
                c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] m_crc32(logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Monitor state.
    bit          stall [3];
    logic [32:0] held [3];
    bit          in_app [3];
    bit          done_prev [3];
    int          done_cnt [3];
    int          last_cnt [3];
    int          xfer_cnt [3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                stall[k]     = 1'b0;
                in_app[k]    = 1'b0;
                done_prev[k] = 1'b0;
            end else begin
                if (stall[k])
                    check("stall_hold", {31'h0, mv[k], ml[k], md[k]},
                          {31'h0, 1'b1, held[k]});
                if (in_app[k])
                    check("s_ready_in_append", {63'h0, sr[k]}, 64'h0);
                if (mv[k] && mr[k]) begin
                    xfer_cnt[k]++;
                    if (ml[k]) last_cnt[k]++;
                    if (exp_q[k].size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        logic [32:0] e;
                        e = exp_q[k].pop_front();
                        check("out_word", {31'h0, ml[k], md[k]}, {31'h0, e});
                    end
                end
                if (cd[k]) begin
                    done_cnt[k]++;
                    if (done_prev[k]) fail_now("crc_done_width");
                    if (crc_q[k].size() == 0) begin
                        fail_now("unexpected_crc_done");
                    end else begin
                        logic [63:0] c;
                        c = crc_q[k].pop_front();
                        check("crc_value_at_done", cv[k], c);
                    end
                end
                done_prev[k] = cd[k];
                stall[k]     = mv[k] && !mr[k];
                held[k]      = {ml[k], md[k]};
                if (sv[k] && sr[k] && sl[k]) in_app[k] = 1'b1;
                if (mv[k] && mr[k] && ml[k]) in_app[k] = 1'b0;
            end
        end
    end

    bit bp = 1'b0;
    always @(posedge clk) begin
        if (bp) begin
            #1;
            mr[0] = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic send(int k, logic [31:0] w[$], bit l[$],
                        logic [63:0] c[$]);
        bit ok;
        int t;
        for (int i = 0; i < w.size(); i++) begin
            ok    = 1'b0;
            t     = 0;
            sv[k] = 1'b1;
            sd[k] = w[i];
            sl[k] = l[i];
            while (!ok && t < 200) begin
                @(negedge clk);
                if (sr[k]) begin
                    ok = 1'b1;
                    exp_q[k].push_back({1'b0, w[i]});
                    if (l[i]) push_crc(k, c.pop_front());
                end
                @(posedge clk);
                #1;
                t++;
            end
            if (!ok) fail_now("send_timeout");
        end
        sv[k] = 1'b0;
        sl[k] = 1'b0;
    endtask

    task automatic drain(int k);
        int t;
        t = 0;
        while (exp_q[k].size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (exp_q[k].size() != 0) fail_now("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [7:0]  s9 [$];
    logic [31:0] w9 [$];
    bit          l9 [$];
    logic [31:0] w4 [$];
    bit          l4 [$];
    logic [31:0] wb [$];
    bit          lb [$];
    logic [31:0] w32 [$];
    bit          l32 [$];
    logic [7:0]  s8 [$];
    logic [7:0]  sa [$];
    logic [31:0] crc32_exp;
    logic [15:0] crc_a;
    string       str9;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        str9 = "123456789";
        for (int i = 0; i < 9; i++) begin
            s9.push_back(str9[i]);
            w9.push_back({24'h0, str9[i]});
            l9.push_back(i == 8);
            if (i < 8) s8.push_back(str9[i]);
            if (i < 4) begin
                w4.push_back({24'h0, str9[i]});
                l4.push_back(1'b0);
            end
        end
        w32.push_back({s8[3], s8[2], s8[1], s8[0]});
        w32.push_back({s8[7], s8[6], s8[5], s8[4]});
        l32.push_back(1'b0);
        l32.push_back(1'b1);
        crc32_exp = m_crc32(s8);
        sa.push_back(8'h41);
        crc_a = m_buypass(sa);
        wb.push_back(32'h41);
        lb.push_back(1'b1);
        foreach (w9[i]) begin
            wb.push_back(w9[i]);
            lb.push_back(l9[i]);
        end
        for (int k = 0; k < 3; k++) begin
            sv[k] = 1'b0;
            sd[k] = 32'h0;
            sl[k] = 1'b0;
            mr[k] = 1'b1;
            done_cnt[k] = 0;
            last_cnt[k] = 0;
            xfer_cnt[k] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", {63'h0, mv[0]}, 64'h0);
        check("rst_m_data", {32'h0, md[0]}, 64'h0);
        check("rst_m_last", {63'h0, ml[0]}, 64'h0);
        check("rst_crc_value", cv[0], 64'h0);
        check("rst_crc_done", {63'h0, cd[0]}, 64'h0);
        check("rst_s_ready", {63'h0, sr[0]}, 64'h1);
        check("rst_crc32_value", cv[2], 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(0, w9, l9, '{64'hFEE8});
        drain(0);
        check("buypass_crc_value", cv[0], 64'hFEE8);
        check("buypass_done_cnt", 64'(done_cnt[0]), 64'd1);
        check("buypass_xfers", 64'(xfer_cnt[0]), 64'd11);

        send(1, w9, l9, '{64'hBB3D});
        drain(1);
        check("arc_crc_value", cv[1], 64'hBB3D);

        send(2, w32, l32, '{{32'h0, crc32_exp}});
        drain(2);
        check("crc32_value", cv[2], {32'h0, crc32_exp});
        check("crc32_last_words", 64'(last_cnt[2]), 64'd1);
        check("crc32_xfers", 64'(xfer_cnt[2]), 64'd3);

        bp = 1'b1;
        send(0, w9, l9, '{64'hFEE8});
        drain(0);
        bp = 1'b0;
        @(posedge clk);
        #2;
        mr[0] = 1'b1;
        check("bp_crc_value", cv[0], 64'hFEE8);
        check("bp_done_cnt", 64'(done_cnt[0]), 64'd2);

        send(0, wb, lb, '{{48'h0, crc_a}, 64'hFEE8});
        drain(0);
        check("b2b_crc_value", cv[0], 64'hFEE8);
        check("b2b_done_cnt", 64'(done_cnt[0]), 64'd4);

        send(0, w4, l4, '{});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_m_valid", {63'h0, mv[0]}, 64'h0);
        check("midrst_m_data", {32'h0, md[0]}, 64'h0);
        check("midrst_m_last", {63'h0, ml[0]}, 64'h0);
        check("midrst_crc_value", cv[0], 64'h0);
        check("midrst_crc_done", {63'h0, cd[0]}, 64'h0);
        @(posedge clk);
        #1;
        exp_q[0].delete();
        crc_q[0].delete();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", {63'h0, mv[0]}, 64'h0);
        @(posedge clk);
        #1;
        send(0, w9, l9, '{64'hFEE8});
        drain(0);
        check("resend_crc_value", cv[0], 64'hFEE8);
        check("resend_done_cnt", 64'(done_cnt[0]), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
